// File: rtl/binary_counter_updown_param.sv
// Parameterised up/down modulo-MODULUS counter with load, terminal count and wrap pulse.
// Define BINARY_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module binary_counter_updown_param #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             terminal_count,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("binary_counter_updown_param: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("binary_counter_updown_param: MODULUS must be 2..2**WIDTH");
  end

  // One extra bit so MODULUS=2**WIDTH is representable and borrow is visible.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   inc_x, dec_x, ld_x;
  logic             at_top, at_bot;
  logic [WIDTH-1:0] q_ld, q_cnt, q_nxt;
  logic             wrap_nxt;

  assign inc_x = {1'b0, q} + ONE_X;
  assign dec_x = {1'b0, q} - ONE_X;
  assign ld_x  = {1'b0, load_value};

  assign at_top = (inc_x == MOD_X);
  assign at_bot = dec_x[WIDTH];

  assign terminal_count = up_down ? at_top : at_bot;
  assign q_ld           = (ld_x < MOD_X) ? load_value : MAX_Q;

`ifdef BINARY_COUNTER_SATURATE_EN
  assign q_cnt = terminal_count ? q : (up_down ? inc_x[WIDTH-1:0] : dec_x[WIDTH-1:0]);
`else
  assign q_cnt = up_down ? (at_top ? '0 : inc_x[WIDTH-1:0])
                         : (at_bot ? MAX_Q : dec_x[WIDTH-1:0]);
`endif

  // An enabled step from the terminal value flags wrap (or saturation).
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = q_ld;
    end else if (enable) begin
      q_nxt    = q_cnt;
      wrap_nxt = terminal_count;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_binary_counter_updown_param.sv
// Directed bench: three counters (W4/M16, W4/M10, W1/M2) share one stimulus stream.
module tb_binary_counter_updown_param;

`ifdef BINARY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [3:0] q16, qb16, q10, qb10;
  logic [0:0] q2, qb2;
  logic       tc16, tc10, tc2, w16, w10, w2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  binary_counter_updown_param #(.WIDTH(4), .MODULUS(16)) u16 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv), .q(q16), .qbar(qb16), .terminal_count(tc16), .wrap(w16));

  binary_counter_updown_param #(.WIDTH(4), .MODULUS(10)) u10 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv), .q(q10), .qbar(qb10), .terminal_count(tc10), .wrap(w10));

  binary_counter_updown_param #(.WIDTH(1), .MODULUS(2)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[0]), .q(q2), .qbar(qb2), .terminal_count(tc2), .wrap(w2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; up_down = 1'b1; enable = 1'b1; load = 1'b1; lv = 4'd7;
    step();
    checks++; if (q16 !== 4'd0)    begin errors++; $display("FAIL reset_q got %0d want 0", q16); end
    checks++; if (qb16 !== 4'hF)   begin errors++; $display("FAIL reset_qbar got %h want f", qb16); end
    checks++; if (w16 !== 1'b0)    begin errors++; $display("FAIL reset_wrap got %b want 0", w16); end
    checks++; if (tc16 !== 1'b0)   begin errors++; $display("FAIL reset_tc_up got %b want 0", tc16); end
    up_down = 1'b0;
    #1;
    checks++; if (tc16 !== 1'b1)   begin errors++; $display("FAIL reset_tc_down got %b want 1", tc16); end
    reset = 1'b0; enable = 1'b0; load = 1'b0; lv = 4'd0;
  endtask

  task automatic test_count_up();
    logic [3:0] eq16;
    logic       ew16, eq2, ew2;
    do_reset();
    up_down = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      eq16 = SAT ? ((i > 15) ? 4'd15 : 4'(i)) : 4'(i % 16);
      ew16 = (i == 16) || (SAT && i > 16);
      eq2  = SAT ? 1'b1 : 1'(i % 2);
      ew2  = SAT ? (i >= 2) : (i % 2 == 0);
      checks++; if (q16 !== eq16)  begin errors++; $display("FAIL up16_q[%0d] got %0d want %0d", i, q16, eq16); end
      checks++; if (qb16 !== ~eq16) begin errors++; $display("FAIL up16_qbar[%0d] got %h want %h", i, qb16, ~eq16); end
      checks++; if (w16 !== ew16)  begin errors++; $display("FAIL up16_wrap[%0d] got %b want %b", i, w16, ew16); end
      checks++; if (q2 !== eq2)    begin errors++; $display("FAIL tff_q[%0d] got %b want %b", i, q2, eq2); end
      checks++; if (w2 !== ew2)    begin errors++; $display("FAIL tff_wrap[%0d] got %b want %b", i, w2, ew2); end
      if (i == 15) begin
        checks++; if (tc16 !== 1'b1) begin errors++; $display("FAIL up16_tc got %b want 1", tc16); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] eq;
    do_reset();
    up_down = 1'b0;
    #1;
    checks++; if (tc10 !== 1'b1) begin errors++; $display("FAIL down10_tc got %b want 1", tc10); end
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      eq = SAT ? 4'd0 : 4'(10 - i);
      checks++; if (q10 !== eq) begin errors++; $display("FAIL down10_q[%0d] got %0d want %0d", i, q10, eq); end
      checks++; if (w10 !== (SAT || i == 1)) begin errors++; $display("FAIL down10_wrap[%0d] got %b want %b", i, w10, (SAT || i == 1)); end
    end
    enable = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; lv = 4'd12; enable = 1'b0;
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL load_clamp got %0d want 9", q10); end
    checks++; if (q16 !== 4'd12) begin errors++; $display("FAIL load_16 got %0d want 12", q16); end
    lv = 4'd5; enable = 1'b1; up_down = 1'b1;
    step();
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL load_over_enable got %0d want 5", q10); end
    checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL load_wrap got %b want 0", w10); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_load_tc_reverse();
    logic [3:0] seq [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
    load = 1'b1; lv = 4'd9; up_down = 1'b1;
    step();
    checks++; if (tc10 !== 1'b1) begin errors++; $display("FAIL tc_at_9 got %b want 1", tc10); end
    lv = 4'd3; enable = 1'b1;
    step();
    checks++; if (q10 !== 4'd3) begin errors++; $display("FAIL load_at_tc got %0d want 3", q10); end
    checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL load_at_tc_wrap got %b want 0", w10); end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_down = (i % 2 == 0);
      step();
      checks++; if (q10 !== seq[i]) begin errors++; $display("FAIL toggle_q[%0d] got %0d want %0d", i, q10, seq[i]); end
    end
    load = 1'b1; lv = 4'd9; enable = 1'b0;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    step();
    checks++; if (q10 !== 4'd8) begin errors++; $display("FAIL reverse_at_top got %0d want 8", q10); end
    checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL reverse_wrap got %b want 0", w10); end
    enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    load = 1'b1; lv = 4'd7;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b1; reset = 1'b1;
    step();
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL midreset_q got %0d want 0", q10); end
    checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL midreset_wrap got %b want 0", w10); end
    reset = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL hold_q[%0d] got %0d want 0", i, q10); end
    end
    load = 1'b1; lv = 4'd9;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    checks++; if (w10 !== 1'b1) begin errors++; $display("FAIL pending_wrap got %b want 1", w10); end
    checks++; if (q10 !== (SAT ? 4'd9 : 4'd0)) begin errors++; $display("FAIL pending_q got %0d", q10); end
    reset = 1'b1;
    step();
    checks++; if (w10 !== 1'b0) begin errors++; $display("FAIL reset_clears_wrap got %b want 0", w10); end
    reset = 1'b0; enable = 1'b0;
  endtask

`ifdef BINARY_COUNTER_SATURATE_EN
  task automatic test_saturate();
    logic [3:0] eq;
    do_reset();
    up_down = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      eq = (i > 15) ? 4'd15 : 4'(i);
      checks++; if (q16 !== eq) begin errors++; $display("FAIL sat_q[%0d] got %0d want %0d", i, q16, eq); end
      checks++; if (w16 !== (i >= 16)) begin errors++; $display("FAIL sat_wrap[%0d] got %b want %b", i, w16, (i >= 16)); end
    end
    up_down = 1'b0;
    step();
    checks++; if (q16 !== 4'd14) begin errors++; $display("FAIL sat_down_q got %0d want 14", q16); end
    checks++; if (w16 !== 1'b0) begin errors++; $display("FAIL sat_down_wrap got %b want 0", w16); end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_tc_reverse();
    test_mid_reset();
`ifdef BINARY_COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
